ball_motion_ctl: RTL

Parametrised successor of the single bouncing-ball animator. It moves one rectangular sprite with a programmable per-axis speed and clamps it exactly at the screen edges, so it never overshoots. A launch/pause FSM gates the motion, and one-cycle bounce events are emitted for sound and score logic. It sits between the animation-strobe generator and the VGA pixel compositor, which consumes o_x1..o_y2.

---
 rtl/ball_pkg.sv | 15 +
 rtl/ball_axis_step.sv | 98 +++++++++
 rtl/ball_motion_ctl.sv | 114 +++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared definitions for the ball motion controller: FSM state encoding
// and the default coordinate width and screen dimensions.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_e;

  localparam int DEF_COORD_W  = 12;
  localparam int DEF_D_WIDTH  = 640;
  localparam int DEF_D_HEIGHT = 480;

endpackage

// File: rtl/ball_axis_step.sv
// One axis of sprite motion: position, direction, latched speed and a
// registered one-cycle bounce pulse. Positions are clamped exactly to
// [LO, HI] and never wrap.
// Optional feature macro: BALL_SPEEDUP_EN (each bounce bumps the speed by 1,
// saturating at MAX_SPD).
module ball_axis_step #(
  parameter int COORD_W  = 12,
  parameter int SPD_W    = 4,
  parameter int MAX_SPD  = 8,
  parameter int LO       = 20,
  parameter int HI       = 619,
  parameter int INIT_POS = 320,
  parameter bit INIT_DIR = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [SPD_W-1:0]   i_speed,
  output logic [COORD_W-1:0] o_pos,
  output logic               o_bounce
);

  localparam logic [COORD_W:0]   LO_W     = (COORD_W+1)'(LO);
  localparam logic [COORD_W:0]   HI_W     = (COORD_W+1)'(HI);
  localparam logic [COORD_W-1:0] LO_P     = COORD_W'(LO);
  localparam logic [COORD_W-1:0] HI_P     = COORD_W'(HI);
  localparam logic [COORD_W-1:0] INIT_P   = COORD_W'(INIT_POS);

  logic [COORD_W-1:0] pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [SPD_W-1:0]   spd_q, spd_d;
  logic               bounce_q, bounce_d;

  logic [COORD_W:0]   pos_ext;
  logic [COORD_W:0]   spd_ext;
  logic [COORD_W:0]   nx;
  logic [COORD_W:0]   lo_lim;

  // Next position/direction/speed; the extra bit keeps sums from wrapping
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    spd_d    = spd_q;
    bounce_d = 1'b0;
    pos_ext  = {1'b0, pos_q};
    spd_ext  = (COORD_W+1)'(spd_q);
    nx       = pos_ext + spd_ext;
    lo_lim   = LO_W + spd_ext;
    if (i_load) begin
      pos_d = INIT_P;
      dir_d = INIT_DIR;
      spd_d = i_speed;
    end else if (i_step && (spd_q != '0)) begin
      if (dir_q) begin
        if (nx >= HI_W) begin
          pos_d    = HI_P;
          dir_d    = 1'b0;
          bounce_d = 1'b1;
        end else begin
          pos_d = nx[COORD_W-1:0];
        end
      end else begin
        if (pos_ext <= lo_lim) begin
          pos_d    = LO_P;
          dir_d    = 1'b1;
          bounce_d = 1'b1;
        end else begin
          pos_d = pos_q - COORD_W'(spd_q);
        end
      end
`ifdef BALL_SPEEDUP_EN
      if (bounce_d && ({1'b0, spd_q} < (SPD_W+1)'(MAX_SPD))) begin
        spd_d = spd_q + 1'b1;
      end
`endif
    end
  end

  // Axis state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q    <= INIT_P;
      dir_q    <= INIT_DIR;
      spd_q    <= '0;
      bounce_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      spd_q    <= spd_d;
      bounce_q <= bounce_d;
    end
  end

  assign o_pos    = pos_q;
  assign o_bounce = bounce_q;

endmodule

// File: rtl/ball_motion_ctl.sv
// Bouncing sprite controller: launch/pause FSM gating two independent
// clamped axes, with sprite edge outputs for the pixel compositor.
// Optional feature macro: BALL_SPEEDUP_EN (handled inside ball_axis_step).
module ball_motion_ctl
  import ball_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int H_SIZE   = 20,
  parameter int V_SIZE   = 20,
  parameter int IX       = 320,
  parameter int IY       = 240,
  parameter bit IX_DIR   = 1'b1,
  parameter bit IY_DIR   = 1'b1,
  parameter int SPD_W    = 4,
  parameter int MAX_SPD  = 8,
  parameter int D_WIDTH  = DEF_D_WIDTH,
  parameter int D_HEIGHT = DEF_D_HEIGHT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic [SPD_W-1:0]   i_speed_x,
  input  logic [SPD_W-1:0]   i_speed_y,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_x2,
  output logic [COORD_W-1:0] o_y1,
  output logic [COORD_W-1:0] o_y2,
  output logic               o_bounce_x,
  output logic               o_bounce_y,
  output logic [1:0]         o_state
);

  state_e             state_q, state_d;
  logic               step;
  logic [COORD_W-1:0] cx, cy;

  // Launch/pause state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and step enable; start beats pause and strobe
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    if (i_start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_RUN: begin
          if (i_pause) begin
            state_d = ST_PAUSED;
          end else begin
            step = i_ani_stb;
          end
        end
        ST_PAUSED: begin
          if (!i_pause) state_d = ST_RUN;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  ball_axis_step #(
    .COORD_W (COORD_W),
    .SPD_W   (SPD_W),
    .MAX_SPD (MAX_SPD),
    .LO      (H_SIZE),
    .HI      (D_WIDTH - 1 - H_SIZE),
    .INIT_POS(IX),
    .INIT_DIR(IX_DIR)
  ) u_axis_x (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (i_start),
    .i_step  (step),
    .i_speed (i_speed_x),
    .o_pos   (cx),
    .o_bounce(o_bounce_x)
  );

  ball_axis_step #(
    .COORD_W (COORD_W),
    .SPD_W   (SPD_W),
    .MAX_SPD (MAX_SPD),
    .LO      (V_SIZE),
    .HI      (D_HEIGHT - 1 - V_SIZE),
    .INIT_POS(IY),
    .INIT_DIR(IY_DIR)
  ) u_axis_y (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (i_start),
    .i_step  (step),
    .i_speed (i_speed_y),
    .o_pos   (cy),
    .o_bounce(o_bounce_y)
  );

  assign o_x1    = cx - COORD_W'(H_SIZE);
  assign o_x2    = cx + COORD_W'(H_SIZE);
  assign o_y1    = cy - COORD_W'(V_SIZE);
  assign o_y2    = cy + COORD_W'(V_SIZE);
  assign o_state = state_q;

endmodule
